// File: rtl/knn_query_sequencer.sv
// Training-set buffer and query sequencer that drives the KNN core and returns its prediction.
// Optional watchdog on the prediction wait is enabled by defining KNN_TIMEOUT_EN.
module knn_query_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FEATURES   = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned VW        = DATA_WIDTH * FEATURES,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [VW-1:0] wr_data,
  input  logic          wr_label,
  input  logic          clr,
  input  logic          test_valid,
  input  logic [VW-1:0] test_data,
  output logic          test_ready,
  output logic [VW-1:0] train_data_o,
  output logic          train_label_o,
  output logic          data_valid_o,
  output logic          training_done_o,
  output logic [VW-1:0] test_data_o,
  input  logic          pred_valid_i,
  input  logic          pred_label_i,
  output logic          result_valid,
  output logic          result_label,
  output logic          result_err,
  input  logic          result_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          busy
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StStream, StDone, StWait, StResult} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [VW-1:0] train_data_q, train_data_d;
  logic          train_label_q, train_label_d;
  logic          data_valid_q, data_valid_d;
  logic          done_q, done_d;
  logic [VW-1:0] test_data_q, test_data_d;
  logic          result_valid_q, result_valid_d;
  logic          result_label_q, result_label_d;

  // Each entry stores {label, vector}.
  logic [VW:0]   mem_q [DEPTH];

  logic          is_idle;
  logic          full_w;
  logic          wr_fire;
  logic          test_fire;

  assign is_idle   = (state_q == StIdle);
  assign full_w    = (count_q == CW'(DEPTH));
  assign wr_fire   = is_idle && wr_en && !clr && !full_w;
  assign test_fire = test_valid && test_ready;

  assign test_ready      = is_idle && (count_q != '0) && !clr;
  assign train_data_o    = train_data_q;
  assign train_label_o   = train_label_q;
  assign data_valid_o    = data_valid_q;
  assign training_done_o = done_q;
  assign test_data_o     = test_data_q;
  assign result_valid    = result_valid_q;
  assign result_label    = result_label_q;
  assign count           = count_q;
  assign full            = full_w;
  assign busy            = !is_idle;

`ifdef KNN_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        result_err_q, result_err_d;
  assign result_err = result_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign result_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[count_q[IW-1:0]] <= {wr_label, wr_data};
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rd_idx_d       = rd_idx_q;
    train_data_d   = train_data_q;
    train_label_d  = train_label_q;
    data_valid_d   = data_valid_q;
    done_d         = done_q;
    test_data_d    = test_data_q;
    result_valid_d = result_valid_q;
    result_label_d = result_label_q;
`ifdef KNN_TIMEOUT_EN
    wdog_d         = wdog_q;
    result_err_d   = result_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          count_d = '0;
        end else if (wr_fire) begin
          count_d = count_q + CW'(1);
        end
        if (test_fire) begin
          test_data_d                   = test_data;
          data_valid_d                  = 1'b1;
          {train_label_d, train_data_d} = mem_q[0];
          rd_idx_d                      = CW'(1);
          state_d                       = StStream;
        end
      end
      StStream: begin
        if (rd_idx_q == count_q) begin
          data_valid_d = 1'b0;
          done_d       = 1'b1;
          rd_idx_d     = '0;
          state_d      = StDone;
        end else begin
          data_valid_d                  = 1'b1;
          {train_label_d, train_data_d} = mem_q[rd_idx_q[IW-1:0]];
          rd_idx_d                      = rd_idx_q + CW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StWait;
`ifdef KNN_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      StWait: begin
        if (pred_valid_i) begin
          result_valid_d = 1'b1;
          result_label_d = pred_label_i;
          state_d        = StResult;
`ifdef KNN_TIMEOUT_EN
          result_err_d   = 1'b0;
        end else if (wdog_q == 16'(TIMEOUT - 1)) begin
          // Prediction gave up on: report an aborted query with a zero label.
          result_valid_d = 1'b1;
          result_label_d = 1'b0;
          result_err_d   = 1'b1;
          state_d        = StResult;
        end else begin
          wdog_d = wdog_q + 16'd1;
`endif
        end
      end
      StResult: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      rd_idx_q       <= '0;
      train_data_q   <= '0;
      train_label_q  <= 1'b0;
      data_valid_q   <= 1'b0;
      done_q         <= 1'b0;
      test_data_q    <= '0;
      result_valid_q <= 1'b0;
      result_label_q <= 1'b0;
`ifdef KNN_TIMEOUT_EN
      wdog_q         <= '0;
      result_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_idx_q       <= rd_idx_d;
      train_data_q   <= train_data_d;
      train_label_q  <= train_label_d;
      data_valid_q   <= data_valid_d;
      done_q         <= done_d;
      test_data_q    <= test_data_d;
      result_valid_q <= result_valid_d;
      result_label_q <= result_label_d;
`ifdef KNN_TIMEOUT_EN
      wdog_q         <= wdog_d;
      result_err_q   <= result_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed self-checking bench for knn_query_sequencer (DEPTH=16, 64-bit vectors, TIMEOUT=10).
module tb_knn_query_sequencer;

  localparam int unsigned VW = 64;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [VW-1:0] wr_data = '0;
  logic          wr_label = 1'b0;
  logic          clr = 1'b0;
  logic          test_valid = 1'b0;
  logic [VW-1:0] test_data = '0;
  logic          test_ready;
  logic [VW-1:0] train_data_o;
  logic          train_label_o;
  logic          data_valid_o;
  logic          training_done_o;
  logic [VW-1:0] test_data_o;
  logic          pred_valid_i = 1'b0;
  logic          pred_label_i = 1'b0;
  logic          result_valid;
  logic          result_label;
  logic          result_err;
  logic          result_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [VW-1:0] a [4];
  logic          a_lbl [4];

  knn_query_sequencer #(
    .DATA_WIDTH(8),
    .FEATURES  (8),
    .DEPTH     (16),
    .TIMEOUT   (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_label       (wr_label),
    .clr            (clr),
    .test_valid     (test_valid),
    .test_data      (test_data),
    .test_ready     (test_ready),
    .train_data_o   (train_data_o),
    .train_label_o  (train_label_o),
    .data_valid_o   (data_valid_o),
    .training_done_o(training_done_o),
    .test_data_o    (test_data_o),
    .pred_valid_i   (pred_valid_i),
    .pred_label_i   (pred_label_i),
    .result_valid   (result_valid),
    .result_label   (result_label),
    .result_err     (result_err),
    .result_ready   (result_ready),
    .count          (count),
    .full           (full),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_sample(input logic [VW-1:0] d, input logic l);
    wr_en    = 1'b1;
    wr_data  = d;
    wr_label = l;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic query(input logic [VW-1:0] d);
    test_valid = 1'b1;
    test_data  = d;
    tick();
    test_valid = 1'b0;
  endtask

  initial begin
    a[0] = 64'hA0A0_0000_1111_0001; a_lbl[0] = 1'b1;
    a[1] = 64'hA1A1_0000_2222_0002; a_lbl[1] = 1'b0;
    a[2] = 64'hA2A2_0000_3333_0003; a_lbl[2] = 1'b1;
    a[3] = 64'hA3A3_0000_4444_0004; a_lbl[3] = 1'b1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", data_valid_o, 0);
    chk("rst_done", training_done_o, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_test_ready", test_ready, 0);

    // Load A0..A3 and run one query
    for (int i = 0; i < 4; i++) write_sample(a[i], a_lbl[i]);
    chk("load_count", count, 4);
    chk("load_test_ready", test_ready, 1);
    query(64'h0123_4567_89AB_CDEF);
    pred_valid_i = 1'b1;  // must be ignored while streaming
    pred_label_i = 1'b0;
    chk("q1_test_data_o", test_data_o, 64'h0123_4567_89AB_CDEF);
    chk("q1_busy", busy, 1);
    chk("q1_test_ready", test_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("q1_dv", data_valid_o, 1);
      chk("q1_data", train_data_o, a[i]);
      chk("q1_label", train_label_o, a_lbl[i]);
      chk("q1_done_early", training_done_o, 0);
      tick();
    end
    pred_valid_i = 1'b0;
    chk("q1_done", training_done_o, 1);
    chk("q1_dv_low", data_valid_o, 0);
    chk("q1_data_hold", train_data_o, a[3]);
    tick();
    chk("q1_done_pulse", training_done_o, 0);
    chk("q1_stream_pred_ignored", result_valid, 0);
    tick();
    pred_valid_i = 1'b1;
    pred_label_i = 1'b1;
    tick();
    pred_valid_i = 1'b0;
    pred_label_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("q1_rv_hold", result_valid, 1);
      chk("q1_label_hold", result_label, 1);
      chk("q1_err", result_err, 0);
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("q1_rv_clear", result_valid, 0);
    chk("q1_idle", busy, 0);
    chk("q1_test_ready_again", test_ready, 1);

    // Second query replays the retained buffer; pred in DONE is ignored
    query(64'hFEDC_BA98_7654_3210);
    for (int i = 0; i < 4; i++) begin
      chk("q2_data", train_data_o, a[i]);
      chk("q2_label", train_label_o, a_lbl[i]);
      tick();
    end
    chk("q2_done", training_done_o, 1);
    pred_valid_i = 1'b1;
    pred_label_i = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("q2_done_pred_ignored", result_valid, 0);
    tick();
    pred_valid_i = 1'b0;
    chk("q2_rv", result_valid, 1);
    chk("q2_label", result_label, 0);
    tick();
    result_ready = 1'b0;
    chk("q2_rv_one_cycle", result_valid, 0);
    chk("q2_idle", busy, 0);

    // clr blocks test_ready immediately, then empties the buffer
    clr = 1'b1;
    #1;
    chk("clr_test_ready", test_ready, 0);
    tick();
    clr = 1'b0;
    chk("clr_count", count, 0);

    // Overfill: 17th write dropped
    for (int i = 0; i < 17; i++) write_sample(64'hB000_0000_0000_0000 | 64'(i), i[0]);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    query(64'h5555_5555_5555_5555);
    for (int i = 0; i < 16; i++) begin
      chk("fill_dv", data_valid_o, 1);
      chk("fill_data", train_data_o, 64'hB000_0000_0000_0000 | 64'(i));
      tick();
    end
    chk("fill_done", training_done_o, 1);
    chk("fill_dv_low", data_valid_o, 0);
    tick();
    pred_valid_i = 1'b1;
    pred_label_i = 1'b1;
    result_ready = 1'b1;
    tick();
    pred_valid_i = 1'b0;
    chk("fill_rv", result_valid, 1);
    tick();
    result_ready = 1'b0;
    chk("fill_idle", busy, 0);

    // clr wins over same-cycle wr_en
    clr      = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 64'hDEAD;
    tick();
    clr      = 1'b0;
    wr_en    = 1'b0;
    chk("clrwr_count", count, 0);
    chk("clrwr_full", full, 0);
    test_valid = 1'b1;
    #1;
    chk("empty_test_ready", test_ready, 0);
    tick();
    test_valid = 1'b0;
    chk("empty_no_start", busy, 0);

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) write_sample(a[i], a_lbl[i]);
    query(64'h1);
    tick();
    chk("pre_rst_dv", data_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dv", data_valid_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", count, 0);

`ifdef KNN_TIMEOUT_EN
    // Timeout: count=1 -> WAIT entered at T+3, expires after 10 WAIT cycles
    write_sample(a[0], 1'b1);
    query(64'h2);
    tick(); tick();
    for (int i = 0; i < 9; i++) tick();
    chk("to_rv_before", result_valid, 0);
    tick();
    chk("to_rv", result_valid, 1);
    chk("to_err", result_err, 1);
    chk("to_label", result_label, 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    query(64'h3);
    tick(); tick();
    for (int i = 0; i < 9; i++) tick();
    pred_valid_i = 1'b1;
    pred_label_i = 1'b1;
    tick();
    pred_valid_i = 1'b0;
    chk("to_pred_rv", result_valid, 1);
    chk("to_pred_err", result_err, 0);
    chk("to_pred_label", result_label, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
